// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory requests,
// a 2-entry instruction buffer toward decode, and branch-redirect flushing.
//
// state  | meaning
// IDLE   | first cycle after reset release, nothing issued
// FETCH  | issuing fetches whenever credit allows
// HALTED | Halt held; in-flight words still land and drain to decode
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic                   IMemReq,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  input  logic                   IMemGnt,
  input  logic                   IMemRdValid,
  input  logic [INSTR_WIDTH-1:0] IMemRdData,
  output logic                   InstrValid,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [PC_WIDTH-1:0]    InstrPC,
  output logic [3:0]             OPCode,
  input  logic                   DecodeReady,
  input  logic                   Redirect,
  input  logic [PC_WIDTH-1:0]    RedirectPC,
  input  logic                   Halt
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  localparam logic [PC_WIDTH-1:0] EVEN_MASK = {{(PC_WIDTH-1){1'b1}}, 1'b0};

  state_t                 state, state_next;
  logic [PC_WIDTH-1:0]    pc;
  logic [1:0]             outstanding, drop, fifo_count;
  logic [PC_WIDTH-1:0]    tag0, tag1;
  logic [INSTR_WIDTH-1:0] data0, data1;
  logic [PC_WIDTH-1:0]    dpc0, dpc1;
  logic [2:0]             credit;
  logic                   redirect_en, issue, rsp_drop, push, pop;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (Halt) state_next = HALTED;
      HALTED:  if (!Halt) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  assign redirect_en = Redirect && (state != IDLE);
  assign credit      = {1'b0, outstanding} + {1'b0, fifo_count};
  assign IMemReq     = (state == FETCH) && !Halt && !Redirect && (credit < 3'd2);
  assign IMemAddr    = pc;
  assign issue       = IMemReq && IMemGnt;
  assign rsp_drop    = IMemRdValid && (drop != 2'd0);
  assign push        = IMemRdValid && (drop == 2'd0) && !redirect_en;
  assign pop         = InstrValid && DecodeReady && !redirect_en;

  assign InstrValid = (fifo_count != 2'd0);
  assign Instr      = data0;
  assign InstrPC    = dpc0;
  assign OPCode     = data0[INSTR_WIDTH-1 -: 4];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)           pc <= RESET_PC;
    else if (redirect_en) pc <= RedirectPC & EVEN_MASK;
    else if (issue)       pc <= pc + PC_WIDTH'(2);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) outstanding <= 2'd0;
    else        outstanding <= outstanding + {1'b0, issue} - {1'b0, IMemRdValid};
  end

  // Every request still in flight at a redirect is wrong-path; a response
  // landing in the redirect cycle is discarded too, so it leaves the count.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)           drop <= 2'd0;
    else if (redirect_en) drop <= outstanding - {1'b0, IMemRdValid};
    else if (rsp_drop)    drop <= drop - 2'd1;
  end

  // Request PC tags, oldest in tag0; occupancy tracks outstanding.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tag0 <= '0;
      tag1 <= '0;
    end else begin
      case ({issue, IMemRdValid})
        2'b10: begin
          if (outstanding == 2'd0) tag0 <= pc;
          else                     tag1 <= pc;
        end
        2'b01: tag0 <= tag1;
        2'b11: begin
          if (outstanding == 2'd2) begin
            tag0 <= tag1;
            tag1 <= pc;
          end else begin
            tag0 <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fifo_count <= 2'd0;
      data0      <= '0;
      data1      <= '0;
      dpc0       <= '0;
      dpc1       <= '0;
    end else if (redirect_en) begin
      fifo_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            data0 <= IMemRdData;
            dpc0  <= tag0;
          end else begin
            data1 <= IMemRdData;
            dpc1  <= tag0;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          data0      <= data1;
          dpc0       <= dpc1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            data0 <= IMemRdData;
            dpc0  <= tag0;
          end else begin
            data0 <= data1;
            dpc0  <= dpc1;
            data1 <= IMemRdData;
            dpc1  <= tag0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a fixed-latency in-order memory model
// feeds the DUT; each task checks one scenario against hand-computed values.
module tb_instr_fetch_unit;

  logic        clk;
  logic        Reset;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRdValid;
  logic [15:0] IMemRdData;
  logic        InstrValid;
  logic [15:0] Instr;
  logic [15:0] InstrPC;
  logic [3:0]  OPCode;
  logic        DecodeReady;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        Halt;

  logic        req2, ivalid2, rd_valid2;
  logic [15:0] addr2, instr2, ipc2;
  logic [3:0]  op2;

  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  int cyc = 0;

  logic [15:0] issue_q[$];
  logic [15:0] issue2_q[$];
  logic [15:0] got_instr[$];
  logic [15:0] got_pc[$];
  logic [3:0]  got_op[$];
  logic [15:0] pend_addr[$];
  int          pend_due[$];

  instr_fetch_unit dut (
    .Clock(clk), .Reset(Reset),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRdValid(IMemRdValid), .IMemRdData(IMemRdData),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC), .OPCode(OPCode),
    .DecodeReady(DecodeReady), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Halt(Halt)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFC)) dut_hi (
    .Clock(clk), .Reset(Reset),
    .IMemReq(req2), .IMemAddr(addr2), .IMemGnt(IMemGnt),
    .IMemRdValid(rd_valid2), .IMemRdData(16'h0000),
    .InstrValid(ivalid2), .Instr(instr2), .InstrPC(ipc2), .OPCode(op2),
    .DecodeReady(1'b1), .Redirect(1'b0), .RedirectPC(16'h0000),
    .Halt(1'b0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] hi;
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h9ABC;
    hi = a[4:1] + 4'h3;
    return {hi, a[11:0]};
  endfunction

  // Memory: responses in issue order, lat cycles after the issuing edge.
  initial begin
    logic        iss, iss2;
    logic [15:0] iss_addr;
    IMemRdValid = 1'b0;
    IMemRdData  = 16'h0;
    rd_valid2   = 1'b0;
    forever begin
      @(negedge clk);
      iss      = IMemReq && IMemGnt;
      iss_addr = IMemAddr;
      iss2     = req2 && IMemGnt;
      @(posedge clk);
      cyc++;
      #2;
      if (!Reset) begin
        pend_addr.delete();
        pend_due.delete();
        IMemRdValid = 1'b0;
        rd_valid2   = 1'b0;
      end else begin
        if (iss) begin
          pend_addr.push_back(iss_addr);
          pend_due.push_back(cyc + lat - 1);
        end
        rd_valid2 = iss2;
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
          IMemRdValid = 1'b1;
          IMemRdData  = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          IMemRdValid = 1'b0;
          IMemRdData  = 16'h0;
        end
      end
    end
  end

  // Record issues and deliveries (a pop in a redirect cycle is not a delivery).
  initial begin
    forever begin
      @(negedge clk);
      if (!Reset) begin
        issue_q.delete(); issue2_q.delete();
        got_instr.delete(); got_pc.delete(); got_op.delete();
      end else begin
        if (IMemReq && IMemGnt) issue_q.push_back(IMemAddr);
        if (req2 && IMemGnt && issue2_q.size() < 8) issue2_q.push_back(addr2);
        if (InstrValid && DecodeReady && !Redirect) begin
          got_instr.push_back(Instr);
          got_pc.push_back(InstrPC);
          got_op.push_back(OPCode);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    Reset = 1'b0; lat = l; DecodeReady = rdy; Halt = 1'b0;
    Redirect = 1'b0; RedirectPC = 16'h0; IMemGnt = 1'b1;
    step(2);
    Reset = 1'b1;
    issue_q.delete(); issue2_q.delete();
    got_instr.delete(); got_pc.delete(); got_op.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b0; DecodeReady = 1'b1; Halt = 1'b0; Redirect = 1'b0;
    RedirectPC = 16'h0; IMemGnt = 1'b1;
    @(negedge clk);
    tests_run++; if (IMemReq !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %b want 0", IMemReq); end
    tests_run++; if (IMemAddr !== 16'h0000) begin tests_failed++; $display("FAIL rst_addr: got %h want 0000", IMemAddr); end
    tests_run++; if (InstrValid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", InstrValid); end
    tests_run++; if (Instr !== 16'h0) begin tests_failed++; $display("FAIL rst_instr: got %h want 0000", Instr); end
    tests_run++; if (InstrPC !== 16'h0) begin tests_failed++; $display("FAIL rst_pc: got %h want 0000", InstrPC); end
    tests_run++; if (OPCode !== 4'h0) begin tests_failed++; $display("FAIL rst_op: got %h want 0", OPCode); end
    tests_run++; if (addr2 !== 16'hFFFC) begin tests_failed++; $display("FAIL rst_addr_hi: got %h want fffc", addr2); end
    tests_run++; if ({req2, ivalid2} !== 2'b00) begin tests_failed++; $display("FAIL rst_req_valid_hi: got %b want 00", {req2, ivalid2}); end
    tests_run++; if ({instr2, ipc2, op2} !== 36'h0) begin tests_failed++; $display("FAIL rst_head_hi: got %h want 0", {instr2, ipc2, op2}); end
  endtask

  task automatic test_basic();
    do_reset(1, 1'b1);
    step(12);
    tests_run++;
    if (issue_q.size() < 3 || got_pc.size() < 3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d issues %0d words, want >=3 each", issue_q.size(), got_pc.size());
    end else begin
      tests_run++; if (issue_q[0] !== 16'h0000 || issue_q[1] !== 16'h0002 || issue_q[2] !== 16'h0004) begin
        tests_failed++; $display("FAIL basic_addr: got %h %h %h want 0000 0002 0004", issue_q[0], issue_q[1], issue_q[2]); end
      tests_run++; if (got_instr[0] !== 16'h1234 || got_pc[0] !== 16'h0000 || got_op[0] !== 4'h1) begin
        tests_failed++; $display("FAIL basic_w0: got %h pc %h op %h want 1234 pc 0000 op 1", got_instr[0], got_pc[0], got_op[0]); end
      tests_run++; if (got_instr[1] !== 16'h9ABC || got_pc[1] !== 16'h0002 || got_op[1] !== 4'h9) begin
        tests_failed++; $display("FAIL basic_w1: got %h pc %h op %h want 9abc pc 0002 op 9", got_instr[1], got_pc[1], got_op[1]); end
      tests_run++; if (got_instr[2] !== 16'h5004 || got_pc[2] !== 16'h0004 || got_op[2] !== 4'h5) begin
        tests_failed++; $display("FAIL basic_w2: got %h pc %h op %h want 5004 pc 0004 op 5", got_instr[2], got_pc[2], got_op[2]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0);
    step(10);
    tests_run++; if (issue_q.size() != 2) begin tests_failed++; $display("FAIL bp_issues: got %0d want 2", issue_q.size()); end
    tests_run++; if (IMemReq !== 1'b0) begin tests_failed++; $display("FAIL bp_req: got %b want 0", IMemReq); end
    tests_run++; if (InstrValid !== 1'b1 || Instr !== 16'h1234 || InstrPC !== 16'h0000) begin
      tests_failed++; $display("FAIL bp_head: got v%b %h pc %h want v1 1234 pc 0000", InstrValid, Instr, InstrPC); end
    DecodeReady = 1'b1;
    step(12);
    tests_run++;
    if (got_pc.size() < 4) begin
      tests_failed++; $display("FAIL bp_count: got %0d words want >=4", got_pc.size());
    end else begin
      tests_run++; if (got_pc[0] !== 16'h0000 || got_pc[1] !== 16'h0002 || got_pc[2] !== 16'h0004 || got_pc[3] !== 16'h0006) begin
        tests_failed++; $display("FAIL bp_order: got %h %h %h %h want 0000 0002 0004 0006", got_pc[0], got_pc[1], got_pc[2], got_pc[3]); end
      tests_run++; if (got_instr[1] !== 16'h9ABC || got_instr[2] !== 16'h5004 || got_instr[3] !== 16'h6006) begin
        tests_failed++; $display("FAIL bp_data: got %h %h %h want 9abc 5004 6006", got_instr[1], got_instr[2], got_instr[3]); end
    end
  endtask

  task automatic test_redirect_drop();
    bit seen = 0;
    do_reset(3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (issue_q.size() >= 2) begin seen = 1; break; end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL rd_wait: got %0d issues want 2 within 20 cycles", issue_q.size());
    end else begin
      Redirect = 1'b1; RedirectPC = 16'h0041;
      #1;
      tests_run++; if (IMemReq !== 1'b0) begin tests_failed++; $display("FAIL rd_req: got %b want 0", IMemReq); end
      step(1);
      Redirect = 1'b0;
      step(14);
      tests_run++;
      if (issue_q.size() < 3 || got_pc.size() < 2) begin
        tests_failed++; $display("FAIL rd_count: got %0d issues %0d words", issue_q.size(), got_pc.size());
      end else begin
        tests_run++; if (issue_q[2] !== 16'h0040) begin tests_failed++; $display("FAIL rd_addr: got %h want 0040", issue_q[2]); end
        tests_run++; if (got_pc[0] !== 16'h0040 || got_instr[0] !== 16'h3040 || got_op[0] !== 4'h3) begin
          tests_failed++; $display("FAIL rd_w0: got pc %h %h op %h want pc 0040 3040 op 3", got_pc[0], got_instr[0], got_op[0]); end
        tests_run++; if (got_pc[1] !== 16'h0042 || got_instr[1] !== 16'h4042) begin
          tests_failed++; $display("FAIL rd_w1: got pc %h %h want pc 0042 4042", got_pc[1], got_instr[1]); end
      end
    end
  endtask

  task automatic test_redirect_pop_rsp();
    bit seen = 0;
    do_reset(1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (InstrValid) begin seen = 1; break; end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL rp_wait: InstrValid got 0 want 1 within 20 cycles");
    end else begin
      tests_run++; if (Instr !== 16'h1234) begin tests_failed++; $display("FAIL rp_head: got %h want 1234", Instr); end
      Redirect = 1'b1; RedirectPC = 16'h0080;
      step(1);
      Redirect = 1'b0;
      tests_run++; if (InstrValid !== 1'b0) begin tests_failed++; $display("FAIL rp_flush: got %b want 0", InstrValid); end
      tests_run++; if (got_pc.size() != 0) begin tests_failed++; $display("FAIL rp_nodeliver: got %0d words want 0", got_pc.size()); end
      step(10);
      tests_run++;
      if (issue_q.size() < 3 || got_pc.size() < 1) begin
        tests_failed++; $display("FAIL rp_count: got %0d issues %0d words", issue_q.size(), got_pc.size());
      end else begin
        tests_run++; if (issue_q[2] !== 16'h0080) begin tests_failed++; $display("FAIL rp_addr: got %h want 0080", issue_q[2]); end
        tests_run++; if (got_pc[0] !== 16'h0080 || got_instr[0] !== 16'h3080) begin
          tests_failed++; $display("FAIL rp_w0: got pc %h %h want pc 0080 3080", got_pc[0], got_instr[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    do_reset(3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (issue_q.size() >= 2) begin seen = 1; break; end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL b2b_wait: got %0d issues want 2 within 20 cycles", issue_q.size());
    end else begin
      Redirect = 1'b1; RedirectPC = 16'h0100;
      step(1);
      RedirectPC = 16'h0201;
      step(1);
      Redirect = 1'b0;
      step(14);
      tests_run++;
      if (issue_q.size() < 3 || got_pc.size() < 1) begin
        tests_failed++; $display("FAIL b2b_count: got %0d issues %0d words", issue_q.size(), got_pc.size());
      end else begin
        tests_run++; if (issue_q[2] !== 16'h0200) begin tests_failed++; $display("FAIL b2b_addr: got %h want 0200", issue_q[2]); end
        tests_run++; if (got_pc[0] !== 16'h0200 || got_instr[0] !== 16'h3200) begin
          tests_failed++; $display("FAIL b2b_w0: got pc %h %h want pc 0200 3200", got_pc[0], got_instr[0]); end
      end
    end
  endtask

  task automatic test_reset_pc();
    do_reset(1, 1'b1);
    step(12);
    tests_run++;
    if (issue2_q.size() < 3) begin
      tests_failed++; $display("FAIL rpc_count: got %0d issues want >=3", issue2_q.size());
    end else begin
      tests_run++; if (issue2_q[0] !== 16'hFFFC || issue2_q[1] !== 16'hFFFE || issue2_q[2] !== 16'h0000) begin
        tests_failed++; $display("FAIL rpc_addr: got %h %h %h want fffc fffe 0000", issue2_q[0], issue2_q[1], issue2_q[2]); end
    end
  endtask

  task automatic test_halt();
    bit seen = 0;
    do_reset(3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (issue_q.size() >= 1) begin seen = 1; break; end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL halt_wait: got 0 issues want 1 within 20 cycles");
    end else begin
      Halt = 1'b1;
      #1;
      tests_run++; if (IMemReq !== 1'b0) begin tests_failed++; $display("FAIL halt_req: got %b want 0", IMemReq); end
      step(10);
      tests_run++; if (issue_q.size() != 1) begin tests_failed++; $display("FAIL halt_issues: got %0d want 1", issue_q.size()); end
      tests_run++;
      if (got_pc.size() != 1) begin
        tests_failed++; $display("FAIL halt_words: got %0d want 1", got_pc.size());
      end else begin
        tests_run++; if (got_pc[0] !== 16'h0000 || got_instr[0] !== 16'h1234) begin
          tests_failed++; $display("FAIL halt_w0: got pc %h %h want pc 0000 1234", got_pc[0], got_instr[0]); end
      end
      Halt = 1'b0;
      step(10);
      tests_run++;
      if (issue_q.size() < 2 || got_pc.size() < 2) begin
        tests_failed++; $display("FAIL halt_resume: got %0d issues %0d words", issue_q.size(), got_pc.size());
      end else begin
        tests_run++; if (issue_q[1] !== 16'h0002 || got_pc[1] !== 16'h0002) begin
          tests_failed++; $display("FAIL halt_next: got addr %h pc %h want 0002 0002", issue_q[1], got_pc[1]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1, 1'b1);
    step(8);
    tests_run++; if (IMemAddr === 16'h0000) begin tests_failed++; $display("FAIL mid_running: got pc %h want nonzero", IMemAddr); end
    #2;
    Reset = 1'b0;
    #1;
    tests_run++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_flags: got req %b valid %b want 0 0", IMemReq, InstrValid); end
    tests_run++; if (IMemAddr !== 16'h0000) begin tests_failed++; $display("FAIL mid_addr: got %h want 0000", IMemAddr); end
    tests_run++; if (Instr !== 16'h0 || InstrPC !== 16'h0 || OPCode !== 4'h0) begin
      tests_failed++; $display("FAIL mid_head: got %h pc %h op %h want 0000 0000 0", Instr, InstrPC, OPCode); end
  endtask

  initial begin
    Reset = 1'b0; IMemGnt = 1'b1; DecodeReady = 1'b1;
    Halt = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_drop();
    test_redirect_pop_rsp();
    test_back_to_back();
    test_reset_pc();
    test_halt();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
